// File: rtl/rs_pkg.sv
// rs_pkg: GF(2^M) arithmetic, generator polynomial and code-length helpers for the RS encoder
package rs_pkg;
  localparam int M_MAX = 12;
  localparam int NPAR_MAX = 32;
  typedef logic [M_MAX-1:0] sym_t;
  typedef logic [M_MAX:0] poly_t;
  typedef sym_t [NPAR_MAX-1:0] coef_t;
  function automatic sym_t gf_mul(sym_t a, sym_t b, poly_t prim, int m);
    poly_t x;
    sym_t r;
    x = {1'b0, a};
    r = '0;
    for (int i = 0; i < M_MAX; i++) begin
      if (i < m && b[i]) r ^= x[M_MAX-1:0];
      x = x << 1;
      if (x[m]) x ^= prim;
    end
    return r;
  endfunction
  function automatic coef_t gen_poly(int npar, int fcr, poly_t prim, int m);
    sym_t c [NPAR_MAX+1];
    sym_t root;
    coef_t g;
    root = sym_t'(1);
    g = '0;
    for (int j = 0; j <= NPAR_MAX; j++) c[j] = (j == 0) ? sym_t'(1) : '0;
    for (int i = 0; i < fcr; i++) root = gf_mul(root, sym_t'(2), prim, m);
    for (int i = 0; i < npar; i++) begin
      for (int j = NPAR_MAX; j > 0; j--) c[j] = c[j-1] ^ gf_mul(root, c[j], prim, m);
      c[0] = gf_mul(root, c[0], prim, m);
      root = gf_mul(root, sym_t'(2), prim, m);
    end
    for (int j = 0; j < NPAR_MAX; j++) g[j] = (j < npar) ? c[j] : '0;
    return g;
  endfunction
  function automatic int kmax(int m, int npar);
    return (1 << m) - 1 - npar;
  endfunction
endpackage

// File: rtl/rs_gf_cmul.sv
// rs_gf_cmul: combinational GF(2^M) multiply of a symbol by an elaboration-time constant
module rs_gf_cmul
  import rs_pkg::*;
#(
  parameter int M = 8,
  parameter logic [M:0] PRIM_POLY = 'h11D,
  parameter logic [M-1:0] C = '0
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);
  assign y = M'(gf_mul(sym_t'(a), sym_t'(C), poly_t'(PRIM_POLY), M));
endmodule

// File: rtl/rs_enc_stream.sv
// rs_enc_stream: streaming systematic Reed-Solomon encoder with valid/ready handshakes and length guard
module rs_enc_stream
  import rs_pkg::*;
#(
  parameter int M = 8,
  parameter logic [M:0] PRIM_POLY = 'h11D,
  parameter int NPAR = 4,
  parameter int FCR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [M-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         err_len
);
  localparam coef_t G = gen_poly(NPAR, FCR, poly_t'(PRIM_POLY), M);
  localparam int KMAX = kmax(M, NPAR);
  localparam int PW = $clog2(NPAR);
  localparam logic [0:0] MSG = 1'b0, PARITY = 1'b1;
  logic [0:0] state;
  logic [M-1:0] s [NPAR];
  logic [M-1:0] gm [NPAR];
  logic [M-1:0] fb, len;
  logic [PW-1:0] pcnt;
  logic free, acc, at_kmax, p_last, eom;
  assign fb = in_data ^ s[NPAR-1];
  assign free = !out_valid || out_ready;
  assign in_ready = state == MSG && free;
  assign acc = in_valid && in_ready;
  assign at_kmax = len == M'(KMAX - 1);
  assign eom = in_last || at_kmax;
  assign p_last = pcnt == PW'(NPAR - 1);
  for (genvar i = 0; i < NPAR; i++) begin : g_mul
    rs_gf_cmul #(.M(M), .PRIM_POLY(PRIM_POLY), .C(G[i][M-1:0])) u_mul (.a(fb), .y(gm[i]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MSG;
      len <= '0;
      pcnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      err_len <= 1'b0;
      for (int k = 0; k < NPAR; k++) s[k] <= '0;
    end else begin
      err_len <= acc && !in_last && at_kmax;
      if (acc) begin
        s[0] <= gm[0];
        for (int k = 1; k < NPAR; k++) s[k] <= s[k-1] ^ gm[k];
        out_data <= in_data;
        out_valid <= 1'b1;
        out_last <= 1'b0;
        state <= eom ? PARITY : MSG;
        len <= eom ? '0 : len + 1'b1;
        pcnt <= '0;
      end else if (state == PARITY && free) begin
        out_data <= s[NPAR-1];
        out_valid <= 1'b1;
        out_last <= p_last;
        s[0] <= '0;
        for (int k = 1; k < NPAR; k++) s[k] <= s[k-1];
        pcnt <= pcnt + 1'b1;
        state <= p_last ? MSG : PARITY;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rs_enc_stream.sv
// tb_rs_enc_stream: scoreboard bench for rs_enc_stream at M=8/NPAR=4 and M=4/NPAR=2
module tb_rs_enc_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [7:0] idata [2];
  logic ivld [2], ilast [2], ordy [2];
  logic irdy [2], ovld [2], olast [2], err [2];
  logic [7:0] odata [2];
  logic [7:0] oa;
  logic [3:0] ob;
  assign odata[0] = oa;
  assign odata[1] = {4'h0, ob};
  rs_enc_stream #(.M(8), .PRIM_POLY(9'h11D), .NPAR(4), .FCR(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(idata[0]), .in_valid(ivld[0]), .in_last(ilast[0]),
    .in_ready(irdy[0]), .out_data(oa), .out_valid(ovld[0]), .out_last(olast[0]),
    .out_ready(ordy[0]), .err_len(err[0]));
  rs_enc_stream #(.M(4), .PRIM_POLY(5'h13), .NPAR(2), .FCR(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(idata[1][3:0]), .in_valid(ivld[1]), .in_last(ilast[1]),
    .in_ready(irdy[1]), .out_data(ob), .out_valid(ovld[1]), .out_last(olast[1]),
    .out_ready(ordy[1]), .err_len(err[1]));
  typedef struct {logic [7:0] d; logic l;} sym_s;
  typedef struct {int d; logic [7:0] sym; int n; logic [7:0] e [5];} vec_t;
  sym_s src [2][$];
  sym_s q [2][$];
  int msg [2][$];
  int np [2] = '{4, 2};
  int km [2] = '{251, 13};
  int mw [2] = '{8, 4};
  int pp [2] = '{'h11d, 'h13};
  int gfull [2][5] = '{'{1, 'h0f, 'h36, 'h78, 'h40}, '{1, 3, 2, 0, 0}};
  int mlen [2], errcnt [2], lowcnt [2];
  bit err_exp [2], hold [2];
  logic [7:0] hd [2];
  logic hl [2];
  bit gaps, use_model;
  int checks = 0, failures = 0;
  vec_t tbl [3];
  function automatic void chk(string n, int d, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h expected %0h", n, d, a, e);
    end
  endfunction
  function automatic int gmul(int a, int b, int m, int prim);
    int r = 0;
    for (int i = 0; i < m; i++) begin
      if ((b >> i) & 1) r ^= a;
      a = a << 1;
      if ((a >> m) & 1) a ^= prim;
    end
    return r;
  endfunction
  function automatic void push_parity(int d);
    int n = msg[d].size();
    int p [];
    p = new[n + np[d]];
    foreach (p[i]) p[i] = (i < n) ? msg[d][i] : 0;
    for (int i = 0; i < n; i++) begin
      int c = p[i];
      for (int j = 1; j <= np[d]; j++) p[i+j] ^= gmul(c, gfull[d][j], mw[d], pp[d]);
    end
    for (int j = 0; j < np[d]; j++) q[d].push_back('{8'(p[n+j]), j == np[d] - 1});
  endfunction
  function automatic void accept(int d, logic [7:0] data, logic last);
    bit forced = mlen[d] == km[d] - 1;
    msg[d].push_back(int'(data));
    q[d].push_back('{data, 1'b0});
    if (last || forced) begin
      push_parity(d);
      err_exp[d] = forced && !last;
      mlen[d] = 0;
      msg[d].delete();
    end else mlen[d]++;
  endfunction
  task automatic tick();
    sym_s s, e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ivld[d] = src[d].size() > 0 && (!gaps || $urandom_range(3) != 0);
      idata[d] = 8'h00;
      ilast[d] = 1'b0;
      if (ivld[d]) begin
        idata[d] = src[d][0].d;
        ilast[d] = src[d][0].l;
      end
      ordy[d] = !gaps || $urandom_range(2) != 0;
    end
    #1;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        src[d].delete(); q[d].delete(); msg[d].delete();
        mlen[d] = 0; err_exp[d] = 0; hold[d] = 0;
      end
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (hold[d]) begin
        chk("hold_valid", d, 32'(ovld[d]), 32'd1);
        chk("hold_data", d, 32'(odata[d]), 32'(hd[d]));
        chk("hold_last", d, 32'(olast[d]), 32'(hl[d]));
      end
      hold[d] = ovld[d] && !ordy[d];
      hd[d] = odata[d];
      hl[d] = olast[d];
      if (err[d]) errcnt[d]++;
      if (!irdy[d]) lowcnt[d]++;
      chk("err_len", d, 32'(err[d]), 32'(err_exp[d]));
      err_exp[d] = 0;
      if (ovld[d] && ordy[d]) begin
        if (q[d].size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_out dut%0d: got %0h expected none", d, odata[d]);
        end else begin
          e = q[d].pop_front();
          chk("out_data", d, 32'(odata[d]), 32'(e.d));
          chk("out_last", d, 32'(olast[d]), 32'(e.l));
        end
      end
      if (ivld[d] && irdy[d]) begin
        s = src[d].pop_front();
        if (use_model) accept(d, s.d, s.l);
      end
    end
  endtask
  task automatic drain(int maxt);
    int t = 0;
    while ((src[0].size() + src[1].size() + q[0].size() + q[1].size()) > 0 && t < maxt) begin
      tick();
      t++;
    end
    if (t >= maxt) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d cycles expected empty queues", t);
      for (int d = 0; d < 2; d++) begin src[d].delete(); q[d].delete(); end
    end
  endtask
  task automatic run_vec(int t);
    int d = tbl[t].d;
    use_model = 0;
    src[d].push_back('{tbl[t].sym, 1'b1});
    for (int i = 0; i < tbl[t].n; i++) q[d].push_back('{tbl[t].e[i], i == tbl[t].n - 1});
    lowcnt[d] = 0;
    drain(50);
    chk("in_ready_low", d, 32'(lowcnt[d]), 32'(np[d]));
    use_model = 1;
  endtask
  initial begin
    rst = 1'b1; gaps = 0; use_model = 1;
    for (int d = 0; d < 2; d++) begin
      ivld[d] = 0; ilast[d] = 0; idata[d] = 0; ordy[d] = 1;
      mlen[d] = 0; errcnt[d] = 0; lowcnt[d] = 0; err_exp[d] = 0; hold[d] = 0;
    end
    tbl[0].d = 0; tbl[0].sym = 8'h01; tbl[0].n = 5; tbl[0].e = '{8'h01, 8'h0f, 8'h36, 8'h78, 8'h40};
    tbl[1].d = 0; tbl[1].sym = 8'h02; tbl[1].n = 5; tbl[1].e = '{8'h02, 8'h1e, 8'h6c, 8'hf0, 8'h80};
    tbl[2].d = 1; tbl[2].sym = 8'h01; tbl[2].n = 3; tbl[2].e = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h00};
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", d, 32'(ovld[d]), 32'd0);
      chk("rst_out_last", d, 32'(olast[d]), 32'd0);
      chk("rst_out_data", d, 32'(odata[d]), 32'd0);
      chk("rst_err_len", d, 32'(err[d]), 32'd0);
      chk("rst_in_ready", d, 32'(irdy[d]), 32'd1);
    end
    rst = 1'b0;
    for (int t = 0; t < 3; t++) run_vec(t);
    for (int i = 0; i < 10; i++) src[0].push_back('{8'h00, i == 9});
    drain(100);
    src[0].push_back('{8'h01, 1'b1});
    repeat (4) tick();
    chk("mid_parity2", 0, 32'(odata[0]), 32'h36);
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", 0, 32'(ovld[0]), 32'd0);
    chk("mid_rst_in_ready", 0, 32'(irdy[0]), 32'd1);
    rst = 1'b0;
    run_vec(0);
    errcnt[0] = 0;
    for (int i = 0; i < 252; i++) src[0].push_back('{8'($urandom_range(255)), i == 251});
    drain(1000);
    chk("err_pulses_252", 0, 32'(errcnt[0]), 32'd1);
    errcnt[0] = 0;
    for (int i = 0; i < 251; i++) src[0].push_back('{8'($urandom_range(255)), i == 250});
    drain(1000);
    chk("err_pulses_251", 0, 32'(errcnt[0]), 32'd0);
    errcnt[1] = 0;
    for (int i = 0; i < 14; i++) src[1].push_back('{8'($urandom_range(15)), i == 13});
    drain(100);
    chk("err_pulses_14", 1, 32'(errcnt[1]), 32'd1);
    errcnt[1] = 0;
    for (int i = 0; i < 13; i++) src[1].push_back('{8'($urandom_range(15)), i == 12});
    drain(100);
    chk("err_pulses_13", 1, 32'(errcnt[1]), 32'd0);
    gaps = 1;
    for (int f = 0; f < 10; f++) begin
      int len = $urandom_range(251, 1);
      for (int i = 0; i < len; i++) src[0].push_back('{8'($urandom_range(255)), i == len - 1});
    end
    for (int f = 0; f < 20; f++) begin
      int len = $urandom_range(16, 1);
      for (int i = 0; i < len; i++) src[1].push_back('{8'($urandom_range(15)), i == len - 1});
    end
    drain(30000);
    gaps = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
